// File: rtl/multi_fifo_producer_if.sv
// Buffer-SRAM port and multi-channel FIFO write port used by multi_fifo_producer.
// The producer takes the master side; the SRAM and FIFOs sit on the slave side.
interface multi_fifo_producer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int NUM_CH     = 4
);
    logic                  to_buffer_cs;
    logic                  to_buffer_oe;
    logic [ADDR_WIDTH-1:0] to_buffer_addr;
    logic [DATA_WIDTH-1:0] to_buffer_R_data;
    logic                  to_buffer_W_req;
    logic [DATA_WIDTH-1:0] to_buffer_W_data;
    logic [NUM_CH-1:0]     fifo_w_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [NUM_CH-1:0]     fifo_full;

    modport master (
        output to_buffer_cs, to_buffer_oe, to_buffer_addr, to_buffer_W_req, to_buffer_W_data,
        output fifo_w_en, fifo_data,
        input  to_buffer_R_data, fifo_full
    );

    modport slave (
        input  to_buffer_cs, to_buffer_oe, to_buffer_addr, to_buffer_W_req, to_buffer_W_data,
        input  fifo_w_en, fifo_data,
        output to_buffer_R_data, fifo_full
    );
endinterface

// File: rtl/multi_fifo_producer.sv
// Strided SRAM reader that deals words round-robin into NUM_CH FIFOs, bursting
// under request/grant arbitration and absorbing the 1-cycle SRAM read latency.
package single_port_ram_pkg;
    localparam logic CS_ENB   = 1'b1;
    localparam logic CS_DIS   = 1'b0;
    localparam logic OE_ENB   = 1'b1;
    localparam logic OE_DIS   = 1'b0;
    localparam logic WREQ_DIS = 1'b0;
endpackage

package accelerator_pkg;
    localparam int EMPTY_DATA = 0;
endpackage

module multi_fifo_producer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int NUM_CH     = 4,
    parameter int BURST_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_begin,
    input  logic [ADDR_WIDTH-1:0] addr_step,
    input  logic                  step_dir,
    input  logic [ADDR_WIDTH-1:0] addr_end,
    output logic                  busy,
    output logic                  done,
    output logic                  request,
    input  logic                  grant,
    multi_fifo_producer_if.master io
);
    import single_port_ram_pkg::*;

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(BURST_SIZE + 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_SIZE);

    typedef enum logic [2:0] {IDLE, WAIT_GRANT, BURST, DRAIN, FINISH} state_e;

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  pend_q, pend_d;
    logic [CH_W-1:0]       pend_ch_q, pend_ch_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic                  past_end_q, past_end_d;
    logic [ADDR_WIDTH-1:0] step_q, step_d;
    logic                  dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;

    logic                  issue;
    logic [ADDR_WIDTH:0]   next_wide;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  next_past;
    logic                  begin_past;
    logic [NUM_CH-1:0]     w_en;

    // The extra top bit of next_wide is the carry (increment) or borrow (decrement).
    always_comb begin
        next_wide  = dir_q ? ({1'b0, cur_addr_q} - {1'b0, step_q})
                           : ({1'b0, cur_addr_q} + {1'b0, step_q});
        next_addr  = next_wide[ADDR_WIDTH-1:0];
        next_past  = next_wide[ADDR_WIDTH] || (step_q == '0) ||
                     (dir_q ? (next_addr < end_q) : (next_addr > end_q));
        begin_past = step_dir ? (addr_begin < addr_end) : (addr_begin > addr_end);
    end

    // A channel with a write still in flight is skipped; this is what keeps a
    // single-channel build from overrunning its FIFO.
    assign issue = (state_q == BURST) && grant && !io.fifo_full[ch_q] &&
                   !(pend_q && (pend_ch_q == ch_q)) &&
                   (burst_cnt_q < BURST_MAX) && !past_end_q;

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        ch_d        = ch_q;
        pend_d      = 1'b0;
        pend_ch_d   = pend_ch_q;
        cur_addr_d  = cur_addr_q;
        burst_cnt_d = burst_cnt_q;
        past_end_d  = past_end_q;
        step_d      = step_q;
        dir_d       = dir_q;
        end_d       = end_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d = addr_begin;
                    step_d     = addr_step;
                    dir_d      = step_dir;
                    end_d      = addr_end;
                    past_end_d = begin_past;
                    ch_d       = '0;
                    state_d    = WAIT_GRANT;
                end
            end
            WAIT_GRANT: begin
                if (grant) begin
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    pend_d      = 1'b1;
                    pend_ch_d   = ch_q;
                    ch_d        = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    cur_addr_d  = next_addr;
                    past_end_d  = next_past;
                    if ((burst_cnt_q + CNT_W'(1) == BURST_MAX) || next_past) state_d = DRAIN;
                end else if (past_end_q || (burst_cnt_q == BURST_MAX)) begin
                    state_d = DRAIN;
                end
            end
            // The last read's write lands here, so DRAIN never needs to linger.
            DRAIN:   state_d = past_end_q ? FINISH : WAIT_GRANT;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rstn) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            pend_q      <= 1'b0;
            pend_ch_q   <= '0;
            cur_addr_q  <= '0;
            burst_cnt_q <= '0;
            past_end_q  <= 1'b0;
            step_q      <= '0;
            dir_q       <= 1'b0;
            end_q       <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pend_q      <= pend_d;
            pend_ch_q   <= pend_ch_d;
            cur_addr_q  <= cur_addr_d;
            burst_cnt_q <= burst_cnt_d;
            past_end_q  <= past_end_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            end_q       <= end_d;
        end
    end

    always_comb begin
        w_en = '0;
        if (pend_q) w_en[pend_ch_q] = 1'b1;
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);
    assign request = (state_q == WAIT_GRANT) || (state_q == BURST);

    assign io.to_buffer_cs     = issue ? CS_ENB : CS_DIS;
    assign io.to_buffer_oe     = issue ? OE_ENB : OE_DIS;
    assign io.to_buffer_addr   = issue ? cur_addr_q : '0;
    assign io.to_buffer_W_req  = WREQ_DIS;
    assign io.to_buffer_W_data = DATA_WIDTH'(accelerator_pkg::EMPTY_DATA);
    assign io.fifo_w_en        = w_en;
    assign io.fifo_data        = pend_q ? io.to_buffer_R_data : '0;
endmodule

// File: tb/tb_multi_fifo_producer.sv
// Directed bench: a 4-channel and a 1-channel producer read from small SRAM models;
// run configurations and a per-cycle grant table carry hand-computed expectations.
`timescale 1ns/1ps
module tb_multi_fifo_producer;
    import single_port_ram_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 20;
    localparam int NCH = 4;
    localparam int BS  = 4;

    typedef struct {
        logic [AW-1:0] b;
        logic [AW-1:0] s;
        logic          dir;
        logic [AW-1:0] e;
        int            exp_n;
        logic          stall_ch1;
    } run_t;

    typedef struct {
        logic start;
        logic grant;
        logic exp_req;
        logic exp_cs;
        logic exp_busy;
        logic exp_done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          start, start1;
    logic [AW-1:0] addr_begin, addr_step, addr_end;
    logic          step_dir;
    logic          grant, grant1;
    logic          busy, done, request;
    logic          busy1, done1, request1;

    multi_fifo_producer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) bus4 ();
    multi_fifo_producer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(1))   bus1 ();

    multi_fifo_producer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .BURST_SIZE(BS)) dut4 (
        .clk(clk), .rstn(rstn), .start(start), .addr_begin(addr_begin), .addr_step(addr_step),
        .step_dir(step_dir), .addr_end(addr_end), .busy(busy), .done(done),
        .request(request), .grant(grant), .io(bus4)
    );

    multi_fifo_producer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(1), .BURST_SIZE(BS)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .addr_begin(addr_begin), .addr_step(addr_step),
        .step_dir(step_dir), .addr_end(addr_end), .busy(busy1), .done(done1),
        .request(request1), .grant(grant1), .io(bus1)
    );

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC35A;
    endfunction

    always @(posedge clk) begin
        if (bus4.to_buffer_cs == CS_ENB && bus4.to_buffer_oe == OE_ENB)
            bus4.to_buffer_R_data <= mem_f(bus4.to_buffer_addr);
        if (bus1.to_buffer_cs == CS_ENB && bus1.to_buffer_oe == OE_ENB)
            bus1.to_buffer_R_data <= mem_f(bus1.to_buffer_addr);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observation logs, sampled mid-cycle on the falling edge.
    int            cyc = 0;
    logic [AW-1:0] rd_addr_q[$];
    int            wr_ch_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            burst_q[$];
    int            cur_burst = 0;
    logic          req_prev = 1'b0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            viol = 0;
    int            rd1_cyc_q[$];
    logic [DW-1:0] wr1_data_q[$];
    int            done1_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus4.to_buffer_cs == CS_ENB) begin
            if (!grant || !request) viol++;
            if (bus4.fifo_full[rd_addr_q.size() % NCH]) viol++;
            rd_addr_q.push_back(bus4.to_buffer_addr);
            cur_burst++;
            if (cur_burst > BS) viol++;
        end
        if (bus4.fifo_w_en != '0) begin
            if (!$onehot(bus4.fifo_w_en)) viol++;
            if ((bus4.fifo_w_en & bus4.fifo_full) != '0) viol++;
            for (int c = 0; c < NCH; c++) if (bus4.fifo_w_en[c]) wr_ch_q.push_back(c);
            wr_data_q.push_back(bus4.fifo_data);
            wr_cyc_q.push_back(cyc);
        end else if (bus4.fifo_data != '0) begin
            viol++;
        end
        if (req_prev && !request && cur_burst > 0) burst_q.push_back(cur_burst);
        if (!request) cur_burst = 0;
        req_prev = request;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus1.to_buffer_cs == CS_ENB) rd1_cyc_q.push_back(cyc);
        if (bus1.fifo_w_en[0]) wr1_data_q.push_back(bus1.fifo_data);
        if (done1) done1_cnt++;
    end

    task automatic clear_logs();
        rd_addr_q.delete();
        wr_ch_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        burst_q.delete();
        cur_burst = 0;
        done_cnt  = 0;
        viol      = 0;
    endtask

    task automatic run4(input int id, input run_t r);
        logic [AW-1:0] a;
        string         n;
        n = $sformatf("run%0d", id);
        clear_logs();
        addr_begin = r.b;
        addr_step  = r.s;
        step_dir   = r.dir;
        addr_end   = r.e;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        if (r.stall_ch1) begin
            repeat (8) tick();
            for (int k = 0; k < 50 && bus4.fifo_w_en[1]; k++) tick();
            bus4.fifo_full[1] = 1'b1;
            repeat (6) tick();
            bus4.fifo_full[1] = 1'b0;
        end
        for (int k = 0; k < 400 && done_cnt == 0; k++) tick();
        repeat (3) tick();
        check({n, " done pulses"}, done_cnt, 1);
        check({n, " read count"}, rd_addr_q.size(), r.exp_n);
        check({n, " write count"}, wr_data_q.size(), r.exp_n);
        a = r.b;
        for (int i = 0; i < r.exp_n; i++) begin
            if (i < rd_addr_q.size()) check($sformatf("%s addr[%0d]", n, i), rd_addr_q[i], a);
            if (i < wr_data_q.size()) begin
                check($sformatf("%s ch[%0d]", n, i), wr_ch_q[i], i % NCH);
                check($sformatf("%s data[%0d]", n, i), wr_data_q[i], mem_f(a));
            end
            a = r.dir ? a - r.s : a + r.s;
        end
        if (wr_cyc_q.size() > 0) check({n, " done after last write"}, done_cyc, wr_cyc_q[$] + 1);
        check({n, " protocol violations"}, viol, 0);
        check({n, " busy idle"}, busy, 1'b0);
    endtask

    run_t runs[6];
    vec_t vecs[16];

    initial begin
        runs[0] = '{b: 20'd0,       s: 20'd1, dir: 1'b0, e: 20'd9,       exp_n: 10, stall_ch1: 1'b0};
        runs[1] = '{b: 20'd20,      s: 20'd5, dir: 1'b1, e: 20'd3,       exp_n: 4,  stall_ch1: 1'b0};
        runs[2] = '{b: 20'd100,     s: 20'd2, dir: 1'b0, e: 20'd130,     exp_n: 16, stall_ch1: 1'b1};
        runs[3] = '{b: 20'hFFFFE,   s: 20'd4, dir: 1'b0, e: 20'hFFFFF,   exp_n: 1,  stall_ch1: 1'b0};
        runs[4] = '{b: 20'd7,       s: 20'd0, dir: 1'b0, e: 20'd20,      exp_n: 1,  stall_ch1: 1'b0};
        runs[5] = '{b: 20'd30,      s: 20'd1, dir: 1'b0, e: 20'd10,      exp_n: 0,  stall_ch1: 1'b0};

        // Grant toggles 1,0,0,1 inside the first burst of a 6-read run (0x40..0x4F step 3).
        //           start  grant  req   cs    busy  done
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rstn       = 1'b0;
        start      = 1'b0;
        start1     = 1'b0;
        grant      = 1'b0;
        grant1     = 1'b1;
        addr_begin = '0;
        addr_step  = '0;
        addr_end   = '0;
        step_dir   = 1'b0;
        bus4.fifo_full        = '0;
        bus1.fifo_full        = '0;
        bus4.to_buffer_R_data = '0;
        bus1.to_buffer_R_data = '0;
        repeat (2) tick();

        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset request", request, 1'b0);
        check("reset w_en", bus4.fifo_w_en, 4'b0);
        check("reset fifo_data", bus4.fifo_data, 16'h0);
        check("reset cs", bus4.to_buffer_cs, CS_DIS);
        check("reset oe", bus4.to_buffer_oe, OE_DIS);
        check("reset addr", bus4.to_buffer_addr, 20'h0);
        check("tied W_req", bus4.to_buffer_W_req, WREQ_DIS);
        check("tied W_data", bus4.to_buffer_W_data, 16'h0);
        check("reset busy1", busy1, 1'b0);

        tick();
        rstn  = 1'b1;
        grant = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run4(i, runs[i]);
            if (i == 0) begin
                check("run0 bursts", burst_q.size(), 3);
                if (burst_q.size() == 3) begin
                    check("run0 burst0", burst_q[0], 4);
                    check("run0 burst1", burst_q[1], 4);
                    check("run0 burst2", burst_q[2], 2);
                end
            end
            if (i == 1) begin
                check("run1 bursts", burst_q.size(), 1);
                if (burst_q.size() == 1) check("run1 burst0", burst_q[0], 4);
            end
        end

        // Grant-toggling table.
        clear_logs();
        addr_begin = 20'h40;
        addr_step  = 20'd3;
        step_dir   = 1'b0;
        addr_end   = 20'h4F;
        for (int i = 0; i < 16; i++) begin
            start = vecs[i].start;
            grant = vecs[i].grant;
            @(negedge clk);
            check($sformatf("vec%0d request", i), request, vecs[i].exp_req);
            check($sformatf("vec%0d cs", i), bus4.to_buffer_cs, vecs[i].exp_cs ? CS_ENB : CS_DIS);
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d done", i), done, vecs[i].exp_done);
            tick();
        end
        start = 1'b0;
        grant = 1'b1;
        check("grant reads", rd_addr_q.size(), 6);
        if (rd_addr_q.size() == 6) check("grant last addr", rd_addr_q[5], 20'h4F);
        check("grant bursts", burst_q.size(), 2);
        check("grant violations", viol, 0);

        // Reset in the middle of a burst.
        clear_logs();
        addr_begin = 20'd20;
        addr_step  = 20'd5;
        step_dir   = 1'b1;
        addr_end   = 20'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rstn = 1'b0;
        tick();
        @(negedge clk);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst request", request, 1'b0);
        check("midrst w_en", bus4.fifo_w_en, 4'b0);
        check("midrst fifo_data", bus4.fifo_data, 16'h0);
        check("midrst cs", bus4.to_buffer_cs, CS_DIS);
        check("midrst oe", bus4.to_buffer_oe, OE_DIS);
        check("midrst addr", bus4.to_buffer_addr, 20'h0);
        tick();
        rstn = 1'b1;
        repeat (6) tick();
        check("midrst no done", done_cnt, 0);
        run4(6, runs[1]);

        // Single-channel build: one read every other cycle.
        rd1_cyc_q.delete();
        wr1_data_q.delete();
        done1_cnt  = 0;
        addr_begin = 20'd0;
        addr_step  = 20'd1;
        step_dir   = 1'b0;
        addr_end   = 20'd3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 200 && done1_cnt == 0; k++) tick();
        repeat (2) tick();
        check("ch1 done pulses", done1_cnt, 1);
        check("ch1 reads", rd1_cyc_q.size(), 4);
        check("ch1 writes", wr1_data_q.size(), 4);
        for (int i = 1; i < rd1_cyc_q.size(); i++)
            check($sformatf("ch1 gap%0d", i), rd1_cyc_q[i] - rd1_cyc_q[i-1], 2);
        for (int i = 0; i < wr1_data_q.size(); i++)
            check($sformatf("ch1 data%0d", i), wr1_data_q[i], mem_f(AW'(i)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
